// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and status controller for a 2^DEPTH-entry FIFO.
// Converts read/write requests into a RAM write enable, write/read
// addresses and registered full/empty/occupancy/error status.
//
// Request/accept semantics: write and read are requests that may be held
// or dropped at any time. wr_en and rd_ok are the same-cycle acceptances,
// derived combinationally from the registered state. A request is
// consumed only on a rising edge where its acceptance is 1. A rejected
// request changes no state except the one-cycle ovf/unf pulse.
module fifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read,
  input  logic             write,
  output logic             wr_en,
  output logic             rd_ok,
  output logic [DEPTH-1:0] writeAddr,
  output logic [DEPTH-1:0] readAddr,
  output logic             empty,
  output logic             full,
  output logic [DEPTH:0]   count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};

  logic [DEPTH:0] count_next;

  // Acceptance: a write is allowed into a full FIFO only when a pop frees
  // the slot in the same edge; a read needs at least one valid entry.
  always_comb begin
    wr_en = write & (~full | read);
    rd_ok = read & ~empty;
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count;
    if (wr_en && !rd_ok) begin
      count_next = count + 1'b1;
    end else if (!wr_en && rd_ok) begin
      count_next = count - 1'b1;
    end
  end

  // Pointer, occupancy, status and error-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeAddr <= '0;
      readAddr  <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      if (wr_en) begin
        writeAddr <= writeAddr + 1'b1;
      end
      if (rd_ok) begin
        readAddr <= readAddr + 1'b1;
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CAP);
      ovf   <= write & ~wr_en;
      unf   <= read & ~rd_ok;
    end
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller for the FIFO. Turns `read`/`write` requests into a RAM write enable, write/read addresses and full/empty/occupancy status, using two wrapping pointer counters internally. Sits between the FIFO's requesting logic and its dual-port RAM: `writeAddr`/`wr_en` drive the RAM write port, `readAddr` drives the read port.

## Interface
- `DEPTH`, default 4: address width in bits. Capacity is 2^DEPTH entries (16 at default).
- `clk`  input  1  rising-edge clock, the only clock.
- `reset`  input  1  asynchronous, active-low. Acts immediately when 0; released state is 1.
- `read`  input  1  request to pop the oldest entry this cycle.
- `write`  input  1  request to push an entry this cycle.
- `wr_en`  output  1  combinational RAM write enable: the push is accepted this cycle.
- `rd_ok`  output  1  combinational: the pop is accepted this cycle.
- `writeAddr`  output  DEPTH  registered address of the next slot to write.
- `readAddr`  output  DEPTH  registered address of the oldest valid entry.
- `empty`  output  1  registered: no valid entries.
- `full`  output  1  registered: 2^DEPTH valid entries.
- `count`  output  DEPTH+1  registered occupancy, 0..2^DEPTH.
- `ovf`  output  1  registered one-cycle pulse: a write was rejected last cycle.
- `unf`  output  1  registered one-cycle pulse: a read was rejected last cycle.

## Operation
- Reset (`reset`=0, asynchronous): `writeAddr`=0, `readAddr`=0, `count`=0, `empty`=1, `full`=0, `ovf`=0, `unf`=0.
- Acceptance (combinational from current state):
  - `wr_en` = `write` & (~`full` | `read`).
  - `rd_ok` = `read` & ~`empty`.
- Full with both requests: both are accepted. The RAM overwrites the slot being popped in the same edge, and the FIFO stays full.
- Empty with both requests: only the write is accepted. The read is rejected, so `unf` pulses.
- Pointers: `writeAddr` increments by 1 on each accepted write, `readAddr` on each accepted read. Both wrap modulo 2^DEPTH (from 2^DEPTH-1 to 0). Neither pointer moves otherwise.
- Occupancy on each edge:
  - +1 if only the write is accepted.
  - -1 if only the read is accepted.
  - unchanged if both or neither are accepted.
- Flags are derived from the next-state count: `empty` = (count_next==0), `full` = (count_next==2^DEPTH). `empty` and `full` are never both 1.
- Error flags:
  - `ovf` next = `write` & ~`wr_en`.
  - `unf` next = `read` & ~`rd_ok`.
  - Each is an error pulse, not sticky.
- Rejected requests change no state other than `ovf`/`unf`.
- Invariant: `writeAddr` - `readAddr` (mod 2^DEPTH) equals `count` mod 2^DEPTH.

## Timing
- `wr_en` and `rd_ok` respond in the same cycle as the requests. There is no registered latency on acceptance.
- The RAM captures data at `writeAddr` on the same rising edge that `wr_en`=1.
- `writeAddr`, `readAddr`, `count`, `empty`, `full`, `ovf` and `unf` update on the rising edge that ends the request cycle, so they are valid one cycle after the request.
- The first written entry is readable (`empty`=0) in the cycle after the write edge.
- `readAddr` always addresses the oldest entry. Read data appears at the RAM read port according to the RAM's own read latency, which is outside this block.
- Asserting reset mid-operation clears all state immediately, regardless of `clk`. Requests made while in reset are ignored. The first edge after release behaves as a normal edge from the empty state.
- One request pair is processed per cycle, with no bubbles.

## Test plan
- Reset then fill: `reset` 0→1, `write`=1 for 16 cycles (DEPTH=4) -> `wr_en`=1 for all 16, `count` steps 1..16, `full`=1 and `writeAddr`=0 (wrapped) after the 16th edge, `empty`=0 from the first edge.
- Overflow: while full, `write`=1, `read`=0 for 1 cycle -> `wr_en`=0, `ovf`=1 for exactly one cycle, `writeAddr`/`count` unchanged at 0/16.
- Drain and underflow: from full, `read`=1 for 17 cycles -> `rd_ok`=1 for 16, `readAddr` wraps 15→0, `empty`=1 after the 16th edge, 17th cycle `rd_ok`=0 and `unf`=1 one cycle.
- Simultaneous at boundaries:
  - Empty + `read`=`write`=1 -> `count`=1, `empty`=0, `unf`=1, `readAddr` unchanged.
  - Full + both -> `count` stays 16, both pointers +1, `full` stays 1, no `ovf`.
- Mid-operation reset: after 5 writes (`count`=5, `writeAddr`=5), pull `reset`=0 between clock edges -> all outputs at reset values before the next edge, and they stay there while `reset`=0 even with `write`=1.
- Random interleave: 500 cycles of random `read`/`write` against a reference occupancy model -> `count`, `empty`, `full`, `ovf`, `unf` match every cycle, and the pointer-difference invariant holds.
